// File: rtl/endec_job_scheduler.sv
// Job scheduler for the shared convolutional encoder / Viterbi decoder datapath:
// round-robin grant, per-job config latch, staggered stage enables, completion/abort/error pulses.
module endec_job_scheduler #(
    parameter int FRAME_LEN = 16,
    parameter int TB_DEPTH  = 16,
    parameter int RATE_W    = 2,
    parameter int CL_W      = 3,
    parameter int CL_MIN    = 3
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              i_enc_req,
    input  logic              i_dec_req,
    input  logic [RATE_W-1:0] i_code_rate,
    input  logic [CL_W-1:0]   i_constr_len,
    input  logic              i_abort,
    output logic              o_enc_ack,
    output logic              o_dec_ack,
    output logic [RATE_W-1:0] o_code_rate,
    output logic [CL_W-1:0]   o_constr_len,
    output logic              o_mode_sel,
    output logic              o_en_c,
    output logic              o_en_e,
    output logic              o_en_b,
    output logic              o_en_a,
    output logic              o_en_m,
    output logic              o_en_t,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_done_mode,
    output logic              o_aborted,
    output logic              o_cfg_err
);

    localparam int DEC_CNT_W = $clog2(TB_DEPTH + 3);
    localparam int ENC_CNT_W = $clog2(FRAME_LEN);
    localparam int CNT_W     = (DEC_CNT_W > ENC_CNT_W) ? DEC_CNT_W : ENC_CNT_W;

    localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TB_DEPTH + 2);
    localparam logic [CNT_W-1:0] TB_LAST  = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, CFG, ENC_RUN, DEC_RUN, DEC_TB, DONE, ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             favor_dec;
    logic             grant_dec;
    logic             cfg_bad;
    logic             abortable;

    // Decode pipeline stagger, {c, e, b, a, m}: each stage starts one cycle after the one feeding it.
    function automatic logic [4:0] run_enables(input logic [CNT_W-1:0] c);
        int unsigned v;
        v = 32'(c);
        run_enables = {1'b1,
                       v < TB_DEPTH,
                       (v >= 1) && (v <= TB_DEPTH),
                       (v >= 2) && (v <= TB_DEPTH + 1),
                       (v >= 3) && (v <= TB_DEPTH + 2)};
    endfunction

    assign grant_dec = i_dec_req && (!i_enc_req || favor_dec);
    assign cfg_bad   = (o_constr_len < CL_W'(CL_MIN)) || (o_code_rate < RATE_W'(2));
    assign abortable = (state == CFG) || (state == ENC_RUN) || (state == DEC_RUN) || (state == DEC_TB);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            favor_dec    <= 1'b0;
            o_enc_ack    <= 1'b0;
            o_dec_ack    <= 1'b0;
            o_code_rate  <= '0;
            o_constr_len <= '0;
            o_mode_sel   <= 1'b0;
            o_en_c       <= 1'b0;
            o_en_e       <= 1'b0;
            o_en_b       <= 1'b0;
            o_en_a       <= 1'b0;
            o_en_m       <= 1'b0;
            o_en_t       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_done_mode  <= 1'b0;
            o_aborted    <= 1'b0;
            o_cfg_err    <= 1'b0;
        end else begin
            o_enc_ack <= 1'b0;
            o_dec_ack <= 1'b0;
            o_done    <= 1'b0;
            o_aborted <= 1'b0;
            o_cfg_err <= 1'b0;
            // Abort outranks every normal transition of an in-flight job.
            if (i_abort && abortable) begin
                state     <= IDLE;
                cnt       <= '0;
                {o_en_c, o_en_e, o_en_b, o_en_a, o_en_m, o_en_t} <= '0;
                o_busy    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (i_enc_req || i_dec_req) begin
                            state        <= CFG;
                            o_busy       <= 1'b1;
                            o_code_rate  <= i_code_rate;
                            o_constr_len <= i_constr_len;
                            o_mode_sel   <= grant_dec;
                            o_enc_ack    <= !grant_dec;
                            o_dec_ack    <= grant_dec;
                            favor_dec    <= !grant_dec;
                        end
                    end
                    CFG: begin
                        cnt <= '0;
                        if (cfg_bad) begin
                            state <= ERR;
                        end else if (!o_mode_sel) begin
                            state  <= ENC_RUN;
                            o_en_c <= 1'b1;
                        end else begin
                            state <= DEC_RUN;
                            {o_en_c, o_en_e, o_en_b, o_en_a, o_en_m} <= run_enables('0);
                        end
                    end
                    ENC_RUN: begin
                        if (cnt == ENC_LAST) begin
                            state       <= DONE;
                            cnt         <= '0;
                            o_en_c      <= 1'b0;
                            o_done      <= 1'b1;
                            o_done_mode <= o_mode_sel;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DEC_RUN: begin
                        if (cnt == RUN_LAST) begin
                            state  <= DEC_TB;
                            cnt    <= '0;
                            {o_en_c, o_en_e, o_en_b, o_en_a, o_en_m} <= '0;
                            o_en_t <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            {o_en_c, o_en_e, o_en_b, o_en_a, o_en_m} <= run_enables(cnt + CNT_ONE);
                        end
                    end
                    DEC_TB: begin
                        if (cnt == TB_LAST) begin
                            state       <= DONE;
                            cnt         <= '0;
                            o_en_t      <= 1'b0;
                            o_done      <= 1'b1;
                            o_done_mode <= o_mode_sel;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DONE, ERR: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end
                endcase
                if (state == CFG && cfg_bad) begin
                    o_cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule
